// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operator encodings and sequencer state constants
package alu_pkg;

    localparam logic [1:0] MODE_NEG  = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/negate_digit.sv
// rtl/negate_digit.sv - one digit of conditional-invert plus carry-in add
module negate_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] d,
    input  logic             inv,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT-1:0] operand;

    assign operand = inv ? ~d : d;
    assign {cout, s} = {1'b0, operand} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/negate_seq.sv
// rtl/negate_seq.sv - digit-serial negate/abs/pass unit; NEGATE_SEQ_OVF_EN enables overflow
module negate_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_width_check
            $error("negate_seq: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t              state;
    logic [WIDTH-1:0]    op;
    logic [WIDTH-1:0]    res;
    logic                carry;
    logic                inv;
    logic [CW-1:0]       cnt;

    logic                accept;
    logic                inv_next;
    logic                last;
    logic [DIGIT-1:0]    dsum;
    logic                dcarry;
    logic [WIDTH+DIGIT-1:0] res_cat;

    assign ready    = (state != BUSY);
    assign done     = (state == DONE);
    assign result   = res;
    assign accept   = start && ready;
    assign inv_next = (mode == MODE_NEG) || ((mode == MODE_ABS) && a[WIDTH-1]);
    assign last     = (state == BUSY) && (cnt == CW'(N - 1));

    // New digit enters at the MSB end so the LSB digit lands at the bottom after N shifts
    assign res_cat  = {dsum, res};

    negate_digit #(.DIGIT(DIGIT)) u_digit (
        .d    (op[DIGIT-1:0]),
        .inv  (inv),
        .cin  (carry),
        .s    (dsum),
        .cout (dcarry)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            op    <= '0;
            res   <= '0;
            carry <= 1'b0;
            inv   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                BUSY: begin
                    op    <= op >> DIGIT;
                    res   <= res_cat[WIDTH+DIGIT-1:DIGIT];
                    carry <= dcarry;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        op    <= a;
                        cnt   <= '0;
                        inv   <= inv_next;
                        carry <= inv_next;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef NEGATE_SEQ_OVF_EN
    logic a_sign;
    logic ovf;

    // Operand sign must be kept aside because the operand register shifts it out
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_sign <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sign <= a[WIDTH-1];
        end else if (last) begin
            ovf <= inv && a_sign && dsum[DIGIT-1];
        end
    end

    assign overflow = ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_negate_seq.sv
// tb/tb_negate_seq.sv - scoreboard bench for negate_seq with directed vectors
module tb_negate_seq;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int N     = WIDTH / DIGIT;

`ifdef NEGATE_SEQ_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct {
        logic [31:0] r;
        logic        o;
        int          c;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] a;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;

    negate_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=done at cycle %0d want=no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.r);
                chk({mon_e.name, "_ovf"}, {31'b0, overflow}, {31'b0, mon_e.o});
                chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.c));
            end
        end
    end

    // Waits for ready, starts an op, then scrambles mode/a to prove they were latched
    task automatic issue(input logic [1:0] m, input logic [31:0] av, input logic [31:0] er,
                         input logic eo, input bit track, input string name);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: got=ready %b want=1", name, ready);
        end
        start = 1'b1;
        mode  = m;
        a     = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        a     = ~av;
        if (track) begin
            e.r    = er;
            e.o    = eo;
            e.c    = cyc + N;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic busy_poke();
        @(negedge clk);
        chk("busy_ready_low", {31'b0, ready}, 32'd0);
        start = 1'b1;
        mode  = 2'b10;
        a     = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        chk("busy_still_busy", {31'b0, ready}, 32'd0);
    endtask

    initial begin
        int n;
        clr_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        a     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        clr_n = 1'b1;

        issue(2'b00, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b1, "neg5");
        busy_poke();
        issue(2'b01, 32'hFFFF_FF9C, 32'h0000_0064, 1'b0, 1'b1, "abs_m100");
        issue(2'b01, 32'h0000_002A, 32'h0000_002A, 1'b0, 1'b1, "abs_p42");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, OVF,  1'b1, "neg_min");
        issue(2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, "neg_zero");
        issue(2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, "b2b_neg1");
        issue(2'b10, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, "pass10");
        issue(2'b11, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, "pass11");
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, OVF,  1'b1, "abs_min");

        issue(2'b00, 32'h1234_5678, 32'h0, 1'b0, 1'b0, "aborted");
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_ovf", {31'b0, overflow}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", {31'b0, ready}, 32'd1);

        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, "post_rst_neg");

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
